mem_stream_writer: RTL and testbench

//  Initiator for the single-port word memory (wEn/addr/dataIn/dataOut interface).

---
 rtl/mem_stream_writer.sv | 203 ++++++++++++++++++++
 tb/tb_mem_stream_writer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_writer.sv
// mem_stream_writer
//   Byte-stream to word-memory initiator. Bytes arriving on a valid/ready link are
//   packed big-endian (first byte lands in the MSB) into DATA_WIDTH-bit words. Each
//   word is written to the single-port memory at BASE_ADDR + word index; the address
//   wraps modulo 2^ADDRESS_WIDTH. done pulses once word_count words have been written.
//
//   Optional feature macro: MEM_STREAM_WRITER_VERIFY_EN
//     When defined, every write is followed by a read-back of the same address. A
//     mismatch sets the sticky verify_err flag, and the transfer carries on.
//     When undefined, mem_dataOut is ignored and verify_err stays 0.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          begin a transfer (sampled only while idle)
//   word_count     words to write, sampled with start, clamped to DEPTH
//   in_data        stream byte
//   in_valid       stream valid
//   in_ready       stream ready
//   mem_wEn        memory write enable
//   mem_addr       memory address
//   mem_dataIn     memory write data
//   mem_dataOut    memory read data
//   busy           high from the accepted start until done
//   done           one-cycle pulse at the end of a transfer
//   words_written  number of words committed in the current or last transfer
//   verify_err     sticky read-back mismatch flag
//   dbg_state      current FSM state, for observation only
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready are both
// high. The producer holds in_data stable while in_valid is high and not yet accepted.
// in_ready comes from a flop and does not depend on in_valid.
module mem_stream_writer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DEPTH         = 4096,
    parameter int BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH:0]   word_count,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     mem_wEn,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH:0]   words_written,
    output logic                     verify_err,
    output logic [2:0]               dbg_state
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [BIW-1:0]           LAST_BYTE = BIW'(BPW - 1);
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_W   = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0]   ONE_W     = (ADDRESS_WIDTH + 1)'(1);
    localparam logic [ADDRESS_WIDTH-1:0] BASE      = ADDRESS_WIDTH'(BASE_ADDR);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_PACK       = 3'd1;
    localparam logic [2:0] S_WRITE      = 3'd2;
    localparam logic [2:0] S_DONE       = 3'd3;
    localparam logic [2:0] S_VERIFY_RD  = 3'd4;
    localparam logic [2:0] S_VERIFY_CHK = 3'd5;

    logic [2:0]               state_q,         state_d;
    logic [ADDRESS_WIDTH:0]   n_q,             n_d;
    logic [BIW-1:0]           byte_idx_q,      byte_idx_d;
    logic [DATA_WIDTH-1:0]    pack_q,          pack_d;
    logic                     in_ready_q,      in_ready_d;
    logic                     mem_wen_q,       mem_wen_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q,      mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_data_in_q,   mem_data_in_d;
    logic                     busy_q,          busy_d;
    logic                     done_q,          done_d;
    logic [ADDRESS_WIDTH:0]   words_written_q, words_written_d;
    logic                     verify_err_q,    verify_err_d;
    logic [ADDRESS_WIDTH:0]   n_clamped;

`ifndef MEM_STREAM_WRITER_VERIFY_EN
    // Read data has no consumer in this build.
    logic unused_mem_data_out;
    assign unused_mem_data_out = ^mem_dataOut;
`endif

    assign n_clamped = (word_count > DEPTH_W) ? DEPTH_W : word_count;

    always_comb begin
        state_d         = state_q;
        n_d             = n_q;
        byte_idx_d      = byte_idx_q;
        pack_d          = pack_q;
        mem_addr_d      = mem_addr_q;
        mem_data_in_d   = mem_data_in_q;
        words_written_d = words_written_q;
        verify_err_d    = verify_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d             = n_clamped;
                    words_written_d = '0;
                    verify_err_d    = 1'b0;
                    byte_idx_d      = '0;
                    state_d         = (n_clamped == '0) ? S_DONE : S_PACK;
                end
            end
            S_PACK: begin
                if (in_valid && in_ready_q) begin
                    pack_d[DATA_WIDTH - 1 - 8 * int'(byte_idx_q) -: 8] = in_data;
                    if (byte_idx_q == LAST_BYTE) begin
                        byte_idx_d    = '0;
                        mem_data_in_d = pack_d;
                        // words_written doubles as the word index within the transfer.
                        mem_addr_d    = BASE + words_written_q[ADDRESS_WIDTH-1:0];
                        state_d       = S_WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                words_written_d = words_written_q + ONE_W;
`ifdef MEM_STREAM_WRITER_VERIFY_EN
                state_d = S_VERIFY_RD;
`else
                state_d = (words_written_q + ONE_W == n_q) ? S_DONE : S_PACK;
`endif
            end
`ifdef MEM_STREAM_WRITER_VERIFY_EN
            S_VERIFY_RD: begin
                state_d = S_VERIFY_CHK;
            end
            S_VERIFY_CHK: begin
                if (mem_dataOut != mem_data_in_q) begin
                    verify_err_d = 1'b1;
                end
                // words_written was already bumped when the write retired.
                state_d = (words_written_q == n_q) ? S_DONE : S_PACK;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The output flops are decoded from the next state, so each output
        // lines up with the state it describes.
        in_ready_d = (state_d == S_PACK);
        mem_wen_d  = (state_d == S_WRITE);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            n_q             <= '0;
            byte_idx_q      <= '0;
            pack_q          <= '0;
            in_ready_q      <= 1'b0;
            mem_wen_q       <= 1'b0;
            mem_addr_q      <= BASE;
            mem_data_in_q   <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            words_written_q <= '0;
            verify_err_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            n_q             <= n_d;
            byte_idx_q      <= byte_idx_d;
            pack_q          <= pack_d;
            in_ready_q      <= in_ready_d;
            mem_wen_q       <= mem_wen_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_in_q   <= mem_data_in_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            words_written_q <= words_written_d;
            verify_err_q    <= verify_err_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_wEn       = mem_wen_q;
    assign mem_addr      = mem_addr_q;
    assign mem_dataIn    = mem_data_in_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_written = words_written_q;
    assign verify_err    = verify_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_stream_writer.sv
// Bench for mem_stream_writer. Two instances share the stimulus: u_a has BASE_ADDR 0
// and u_b has BASE_ADDR 4094, for the address-wrap case. sel routes start to one
// instance and selects which instance's outputs are observed. The reference model
// turns each byte list into the expected (address, word) writes.
module tb_mem_stream_writer;
    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int BPW   = DW / 8;
    localparam int DEPTH = 4096;
`ifdef MEM_STREAM_WRITER_VERIFY_EN
    localparam int CPW = BPW + 3;
    localparam bit VEN = 1'b1;
`else
    localparam int CPW = BPW + 1;
    localparam bit VEN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, sel = 1'b0, in_valid = 1'b0;
    logic [AW:0]   word_count = '0;
    logic [7:0]    in_data = '0;
    logic [DW-1:0] mem_rd = '0;

    logic          rdy_a, wen_a, busy_a, done_a, verr_a, rdy_b, wen_b, busy_b, done_b, verr_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;
    logic [AW:0]   ww_a, ww_b;
    logic [2:0]    st_a, st_b;

    mem_stream_writer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .word_count(word_count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a), .mem_wEn(wen_a),
        .mem_addr(addr_a), .mem_dataIn(din_a), .mem_dataOut(mem_rd), .busy(busy_a),
        .done(done_a), .words_written(ww_a), .verify_err(verr_a), .dbg_state(st_a));

    mem_stream_writer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(4094)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .word_count(word_count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b), .mem_wEn(wen_b),
        .mem_addr(addr_b), .mem_dataIn(din_b), .mem_dataOut(mem_rd), .busy(busy_b),
        .done(done_b), .words_written(ww_b), .verify_err(verr_b), .dbg_state(st_b));

    logic          in_ready, wen, busy, done, verify_err;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [AW:0]   ww;
    assign in_ready   = sel ? rdy_b  : rdy_a;
    assign wen        = sel ? wen_b  : wen_a;
    assign addr       = sel ? addr_b : addr_a;
    assign din        = sel ? din_b  : din_a;
    assign busy       = sel ? busy_b : busy_a;
    assign done       = sel ? done_b : done_a;
    assign ww         = sel ? ww_b   : ww_a;
    assign verify_err = sel ? verr_b : verr_a;

    int tests = 0;
    int fails = 0;
    longint cyc = 0;
    logic [AW+DW-1:0] exp_q[$];
    longint wr_cyc[$];
    logic [7:0] bq[$];
    logic [DW-1:0] mem [0:DEPTH-1];
    bit corrupt = 1'b0;
    logic [AW+DW-1:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: writes and reads take effect on the falling edge. When corrupt
    // is set, reads of address 1 come back with bit 0 flipped.
    always @(negedge clk) begin
        if (wen) mem[addr] <= din;
        mem_rd <= mem[addr] ^ ((corrupt && addr == AW'(1)) ? DW'(1) : DW'(0));
    end

    // Scoreboard: every write must match the next expected (address, word).
    always @(negedge clk) begin
        if (wen) begin
            check("wr_in_ready_low", in_ready, 0);
            check("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_addr", addr, mon_e[AW+DW-1:DW]);
                check("wr_data", din, mon_e[DW-1:0]);
            end
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check_reset(input string tag, input int base);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wen"}, wen, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_verr"}, verify_err, 0);
        check({tag, "_addr"}, addr, base);
        check({tag, "_din"}, din, 0);
        check({tag, "_ww"}, ww, 0);
    endtask

    task automatic fill_random(input int nbytes);
        bq.delete();
        for (int i = 0; i < nbytes; i++) bq.push_back(8'($urandom_range(0, 255)));
    endtask

    // gap: 0 = back-to-back, 1 = valid every other cycle, 2 = random.
    // poke: pulse start while the transfer is busy.
    task automatic run_xfer(input int n, input int gap, input bit poke);
        int nw, base, k, guard, w;
        bit acc, hit;
        logic [AW-1:0] a;
        nw = (n > DEPTH) ? DEPTH : n;
        base = sel ? 4094 : 0;
        hit = 1'b0;
        for (int i = 0; i < nw; i++) begin
            a = AW'(base + i);
            if (a == AW'(1)) hit = 1'b1;
            exp_q.push_back({a, bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]});
        end
        wr_cyc.delete();
        @(posedge clk); #1;
        start = 1'b1;
        word_count = (AW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("verr_cleared_by_start", verify_err, 0);
        k = 0;
        guard = 0;
        while (k < nw * BPW && guard < 2000) begin
            case (gap)
                0: in_valid = 1'b1;
                1: in_valid = (guard % 2 == 0);
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            in_data = bq[k];
            if (poke) start = (guard % 3 == 1);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("bytes_accepted", k, nw * BPW);
        w = 0;
        while (w < 200) begin
            @(negedge clk);
            w++;
            if (done) break;
        end
        check("done_seen", done, 1);
        if (nw == 0) check("zero_done_latency", w, 1);
        check("busy_at_done", busy, 1);
        check("ww_at_done", ww, nw);
        check("verify_err", verify_err, VEN && corrupt && hit);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("exp_drained", exp_q.size(), 0);
        check("write_count", wr_cyc.size(), nw);
        if (gap == 0) begin
            for (int i = 1; i < wr_cyc.size(); i++)
                check("write_spacing", wr_cyc[i] - wr_cyc[i-1], CPW);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        #12;
        check_reset("reset_a", 0);
        sel = 1'b1;
        #1;
        check_reset("reset_b", 4094);
        sel = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Known pattern, back-to-back bytes
        bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        run_xfer(2, 0, 1'b0);

        // in_valid toggling every other cycle
        fill_random(12);
        run_xfer(3, 1, 1'b0);

        // Zero-length transfer
        bq.delete();
        run_xfer(0, 0, 1'b0);

        // Address wrap on the BASE_ADDR=4094 instance, with start pulses while busy
        sel = 1'b1;
        fill_random(12);
        run_xfer(3, 2, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("no_restart_busy", busy, 0);
        end
        sel = 1'b0;

        // Random transfers on either instance
        for (int t = 0; t < 4; t++) begin
            int n;
            sel = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 5);
            fill_random(n * BPW);
            run_xfer(n, $urandom_range(0, 2), 1'b0);
        end
        sel = 1'b0;

        // Read-back corruption at address 1, then a clean transfer
        corrupt = 1'b1;
        fill_random(12);
        run_xfer(3, 0, 1'b0);
        corrupt = 1'b0;
        fill_random(8);
        run_xfer(2, 0, 1'b0);

        // Reset in the middle of packing
        @(posedge clk); #1;
        start = 1'b1;
        word_count = (AW+1)'(2);
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hAA;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("mid_pack_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid_pack", 0);
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_hold_wen", wen, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_idle", busy, 0);
        check("after_reset_exp", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
